diff_result_fifo: RTL and testbench
===================================

# diff_result_fifo

Downstream capture stage for the 6-bit ripple full-difference subtractor. Each cycle it can accept one operand pair and the subtractor's 7-bit result (`dif[6]` = final borrow). It derives status flags, checks the result against the operands, and buffers entries in a small FIFO. A valid/ready handshake delivers entries to the consumer (register file / display logic).

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer presents an entry.
- `in_ready`  out  1  stage can accept; equals `count != DEPTH`.
- `in_x`  in  6  minuend fed to the subtractor.
- `in_y`  in  6  subtrahend fed to the subtractor.
- `in_dif`  in  7  subtractor output; bit 6 = borrow out.
- `out_valid`  out  1  head entry available; equals `count != 0`.
- `out_ready`  in  1  consumer accepts head.
- `out_dif`  out  7  head result, as captured.
- `out_zero`  out  1  `out_dif[5:0] == 0`.
- `out_borrow`  out  1  `out_dif[6]` (unsigned x < y).
- `out_neg`  out  1  `out_dif[5]` (signed sign bit).
- `out_ovf`  out  1  signed overflow flag (see Configuration).
- `out_err`  out  1  captured result disagreed with operands.
- `count`  out  clog2(DEPTH)+1  occupancy.
- `err_total`  out  8  saturating count of pushed entries with err set.

## Operation
- Push: `in_valid && in_ready`.
  - Flags are computed from the inputs in the push cycle and stored with the 7-bit result.
  - Stored entry: {dif, zero, borrow, neg, ovf, err}.
- Pop: `out_valid && out_ready`. Head advances.
- Error check: `err = (in_dif != ({1'b0,in_x} - {1'b0,in_y}))`, 7-bit modulo-128 arithmetic.
  - Example: x=3, y=5 gives expected 7'b1111110.
- `err_total` increments on each push with err=1 and saturates at 255. It is unaffected by pops.
- Pointers: `wr_ptr` and `rd_ptr` are clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` is tracked separately.
- Count update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- Full (`count==DEPTH`):
  - `in_ready=0`, so a push is impossible even if a pop occurs in the same cycle.
  - No bypass; `in_ready` rises in the cycle after the pop.
- Empty (`count==0`):
  - `out_valid=0`; a pop is ignored.
  - No write-through bypass; a pushed entry appears at the head next cycle.
- Output fields hold while `out_valid && !out_ready`. They are stable under backpressure.
- Output fields while empty show the last-read slot. They are don't-care and are not checked.

## Timing
- Latency: an entry pushed at edge N is visible on `out_*` with `out_valid=1` after edge N (cycle N+1).
- Throughput: one push and one pop per cycle.
- Reset values after reset is sampled high:
  - `count=0`, `out_valid=0`, `in_ready=1`, `err_total=0`, pointers 0.
  - `out_dif`, `out_zero`, `out_borrow`, `out_neg`, `out_ovf`, `out_err` = 0.
  - Storage contents are not cleared.
- Reset mid-operation: reset wins over a simultaneous push or pop. All buffered entries are discarded, and `err_total` clears.
- `in_ready` and `out_valid` are decoded from registered `count` only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `DIFF_FIFO_OVF_EN` defined:
  - `ovf = (in_x[5] ^ in_y[5]) & (in_x[5] ^ in_dif[5])`, stored per entry and driven on `out_ovf`.
- Not defined:
  - No overflow logic or storage bit.
  - `out_ovf` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Basic push: reset, push x=5, y=3, dif=7'b0000010.
  - Next cycle: `out_valid=1`, `out_dif=0000010`, zero=0, borrow=0, neg=0, err=0.
  - Pop: `count` returns to 0.
- Borrow case: push x=3, y=5, dif=7'b1111110.
  - Head: borrow=1, neg=1, zero=0, err=0.
  - Push x=9, y=9, dif=0: zero=1.
- Overflow: push x=6'b100000, y=6'b000001, dif=7'b0011111.
  - With `DIFF_FIFO_OVF_EN`: `out_ovf=1`.
  - Without it: `out_ovf=0`.
- Full/backpressure: hold `out_ready=0` and push DEPTH=4 entries.
  - After the 4th: `count=4`, `in_ready=0`.
  - 5th offered entry is not accepted.
  - Raise `out_ready` for 1 cycle: `count=3`, `in_ready=1`.
  - Heads drain in FIFO order, including through pointer wrap.
- Simultaneous push and pop: with `count=2`, push and pop in the same cycle.
  - `count` stays 2; the popped head is the oldest entry.
- Error check and reset:
  - Push x=4, y=1 with a corrupted dif=7'b0000100: `out_err=1`, `err_total=1`.
  - Assert `reset` with 3 entries buffered: next cycle `count=0`, `out_valid=0`, `err_total=0`.

Source files
------------

// File: rtl/diff_result_fifo.sv
// diff_result_fifo: capture stage behind the 6-bit ripple subtractor.
// Each accepted entry holds the 7-bit result and its derived flags
// (zero, borrow, sign, error, optional overflow). Entries are queued in a
// small FIFO and delivered to the consumer over a valid/ready handshake.
// Optional feature: define DIFF_FIFO_OVF_EN to compute and store the signed
// overflow flag. Without it, out_ovf is tied low and no storage bit exists.
module diff_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 in_x,
    input  logic [5:0]                 in_y,
    input  logic [6:0]                 in_dif,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [6:0]                 out_dif,
    output logic                       out_zero,
    output logic                       out_borrow,
    output logic                       out_neg,
    output logic                       out_ovf,
    output logic                       out_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 err_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef struct packed {
        logic [6:0] dif;
        logic       zero;
        logic       borrow;
        logic       neg;
`ifdef DIFF_FIFO_OVF_EN
        logic       ovf;
`endif
        logic       err;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        in_entry;
    entry_t        head_q, head_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    err_total_q, err_total_d;
    logic [6:0]    dif_expected;
    logic          push, pop;

    // Build the entry to store from this cycle's operands and result.
    always_comb begin
        in_entry        = '0;
        dif_expected    = {1'b0, in_x} - {1'b0, in_y};
        in_entry.dif    = in_dif;
        in_entry.zero   = (in_dif[5:0] == 6'd0);
        in_entry.borrow = in_dif[6];
        in_entry.neg    = in_dif[5];
`ifdef DIFF_FIFO_OVF_EN
        in_entry.ovf    = (in_x[5] ^ in_y[5]) & (in_x[5] ^ in_dif[5]);
`endif
        in_entry.err    = (in_dif != dif_expected);
    end

    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign rd_next   = rd_ptr_q + PTR_ONE;

    // Next-state for pointers, occupancy, error counter and the head register.
    // The head is kept in its own register so it can be reset to zero while
    // storage is not; it loads either the incoming entry (queue empty, or
    // its only entry leaving this cycle) or the slot behind the popped head.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_total_d = err_total_q;
        head_d      = head_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (in_entry.err && (err_total_q != 8'hFF)) begin
                err_total_d = err_total_q + 8'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (push && ((count_q == '0) || (pop && (count_q == CNT_ONE)))) begin
            head_d = in_entry;
        end else if (pop && (count_q > CNT_ONE)) begin
            head_d = mem_q[rd_next];
        end
    end

    // Control and head registers; reset discards all buffered entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_total_q <= '0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_total_q <= err_total_d;
            head_q      <= head_d;
        end
    end

    // Entry storage; contents survive reset and are only written on push.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign out_dif    = head_q.dif;
    assign out_zero   = head_q.zero;
    assign out_borrow = head_q.borrow;
    assign out_neg    = head_q.neg;
    assign out_err    = head_q.err;
`ifdef DIFF_FIFO_OVF_EN
    assign out_ovf    = head_q.ovf;
`else
    assign out_ovf    = 1'b0;
`endif
    assign count      = count_q;
    assign err_total  = err_total_q;

endmodule

// File: tb/tb_diff_result_fifo.sv
// Directed self-checking bench for diff_result_fifo (DEPTH = 4).
module tb_diff_result_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_x = '0;
    logic [5:0] in_y = '0;
    logic [6:0] in_dif = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] out_dif;
    logic       out_zero, out_borrow, out_neg, out_ovf, out_err;
    logic [2:0] count;
    logic [7:0] err_total;

    int total = 0;
    int bad = 0;

    diff_result_fifo #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_dif(in_dif),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dif(out_dif), .out_zero(out_zero), .out_borrow(out_borrow),
        .out_neg(out_neg), .out_ovf(out_ovf), .out_err(out_err),
        .count(count), .err_total(err_total)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [5:0] x, input logic [5:0] y, input logic [6:0] d);
        in_x = x; in_y = y; in_dif = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (err_total !== 8'd0) begin bad++; $display("FAIL rst_err_total got=%0d want=0", err_total); end
        total++; if ({out_dif, out_zero, out_borrow, out_neg, out_ovf, out_err} !== 12'd0) begin
            bad++; $display("FAIL rst_out_fields got=%b want=0", {out_dif, out_zero, out_borrow, out_neg, out_ovf, out_err});
        end
    endtask

    task automatic test_basic();
        push1(6'd5, 6'd3, 7'b0000010);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        total++; if (out_dif !== 7'b0000010) begin bad++; $display("FAIL basic_dif got=%b want=0000010", out_dif); end
        total++; if ({out_zero, out_borrow, out_neg, out_err} !== 4'b0000) begin
            bad++; $display("FAIL basic_flags got=%b want=0000", {out_zero, out_borrow, out_neg, out_err});
        end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", count); end
        pop1();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL basic_pop_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pop_valid got=%b want=0", out_valid); end
        // pop on empty queue must be ignored
        pop1();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_pop_count got=%0d want=0", count); end
    endtask

    task automatic test_borrow();
        push1(6'd3, 6'd5, 7'b1111110);
        total++; if ({out_zero, out_borrow, out_neg, out_err} !== 4'b0110) begin
            bad++; $display("FAIL borrow_flags zbne got=%b want=0110", {out_zero, out_borrow, out_neg, out_err});
        end
        pop1();
        push1(6'd9, 6'd9, 7'd0);
        total++; if ({out_zero, out_borrow, out_neg, out_err} !== 4'b1000) begin
            bad++; $display("FAIL zero_flags zbne got=%b want=1000", {out_zero, out_borrow, out_neg, out_err});
        end
        pop1();
    endtask

    task automatic test_ovf();
        logic exp_ovf;
`ifdef DIFF_FIFO_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        push1(6'b100000, 6'b000001, 7'b0011111);
        total++; if (out_ovf !== exp_ovf) begin bad++; $display("FAIL ovf got=%b want=%b", out_ovf, exp_ovf); end
        total++; if ({out_neg, out_err} !== 2'b00) begin bad++; $display("FAIL ovf_neg_err got=%b want=00", {out_neg, out_err}); end
        pop1();
    endtask

    task automatic test_full();
        logic [6:0] exp_q [4];
        exp_q[0] = 7'd2; exp_q[1] = 7'd3; exp_q[2] = 7'd4; exp_q[3] = 7'd20;
        for (int i = 0; i < 4; i++) push1(6'(i + 1), 6'd0, 7'(i + 1));
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        total++; if (out_dif !== 7'd1) begin bad++; $display("FAIL full_head got=%0d want=1", out_dif); end
        // 5th entry offered while full: refused
        push1(6'd20, 6'd0, 7'd20);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_refuse_count got=%0d want=4", count); end
        // pop while still offering: push blocked because in_ready was low
        in_x = 6'd20; in_y = 6'd0; in_dif = 7'd20; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count got=%0d want=3", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_in_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_refill_count got=%0d want=4", count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (out_dif !== exp_q[i]) begin bad++; $display("FAIL drain_%0d got=%0d want=%0d", i, out_dif, exp_q[i]); end
            pop1();
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", count); end
    endtask

    task automatic test_back_to_back();
        push1(6'd7, 6'd1, 7'd6);
        push1(6'd8, 6'd1, 7'd7);
        total++; if (out_dif !== 7'd6) begin bad++; $display("FAIL b2b_head0 got=%0d want=6", out_dif); end
        in_x = 6'd9; in_y = 6'd1; in_dif = 7'd8; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", count); end
        total++; if (out_dif !== 7'd7) begin bad++; $display("FAIL b2b_head1 got=%0d want=7", out_dif); end
        pop1();
        total++; if (out_dif !== 7'd8) begin bad++; $display("FAIL b2b_head2 got=%0d want=8", out_dif); end
        // single entry replaced by a simultaneous push: new entry becomes head
        in_x = 6'd30; in_y = 6'd10; in_dif = 7'd20; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_one_count got=%0d want=1", count); end
        total++; if (out_dif !== 7'd20) begin bad++; $display("FAIL b2b_one_head got=%0d want=20", out_dif); end
        pop1();
    endtask

    task automatic test_err_reset();
        push1(6'd4, 6'd1, 7'b0000100);
        total++; if (out_err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b want=1", out_err); end
        total++; if (err_total !== 8'd1) begin bad++; $display("FAIL err_total got=%0d want=1", err_total); end
        push1(6'd2, 6'd1, 7'd1);
        push1(6'd3, 6'd1, 7'd2);
        total++; if (err_total !== 8'd1) begin bad++; $display("FAIL err_total_hold got=%0d want=1", err_total); end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL err_count got=%0d want=3", count); end
        // reset wins over simultaneous push and pop
        in_x = 6'd1; in_y = 6'd0; in_dif = 7'd5; in_valid = 1'b1; out_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_mid_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
        total++; if (err_total !== 8'd0) begin bad++; $display("FAIL rst_mid_err_total got=%0d want=0", err_total); end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_borrow();
        test_ovf();
        test_full();
        test_back_to_back();
        test_err_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
